// File: rtl/sed_scheduler.sv
// Sequencer for the SEDAA soft-error-detection primitive: periodic/on-demand CRC
// checks, forced-error self-tests, watchdogs and sticky status for the supervisor.
module sed_scheduler #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned START_TO = 64,
  parameter int unsigned RUN_TO   = 32'd100000000,
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned FRC_LEN  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_interval,
  input  logic             i_req,
  input  logic             i_frc_req,
  input  logic             i_err_clr,
  input  logic             i_sederr,
  input  logic             i_seddone,
  input  logic             i_sedinprog,
  output logic             o_sedenable,
  output logic             o_sedstart,
  output logic             o_sedfrcerr,
  output logic             o_busy,
  output logic             o_err_sticky,
  output logic             o_frc_fail,
  output logic             o_timeout,
  output logic             o_irq,
  output logic [15:0]      o_chk_cnt,
  output logic [7:0]       o_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SETTLE, S_START, S_RUN, S_EVAL, S_FORCE, S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE - 32'd1);
  localparam logic [CNT_W-1:0] LD_START  = CNT_W'(START_TO - 32'd1);
  localparam logic [CNT_W-1:0] LD_RUN    = CNT_W'(RUN_TO - 32'd1);
  localparam logic [CNT_W-1:0] LD_FRC    = CNT_W'(FRC_LEN - 32'd1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_err_sync, r_done_sync, r_inprog_sync;
  logic             r_done_d, r_pend_req, r_pend_frc;
  logic             r_sedenable, r_sedstart, r_sedfrcerr, r_busy;
  logic             r_err_sticky, r_frc_fail, r_timeout, r_irq;
  logic [15:0]      r_chk_cnt;
  logic [7:0]       r_err_cnt;
  logic             w_err, w_inprog, w_done_edge, w_cnt_zero, w_pend_arm;
  logic             w_to_set, w_chk_inc, w_err_hit, w_frc_fail, w_frc_pass, w_pend_clr;

  assign w_err       = r_err_sync[1];
  assign w_inprog    = r_inprog_sync[1];
  assign w_done_edge = r_done_sync[1] & ~r_done_d;
  assign w_cnt_zero  = (r_cnt == {CNT_W{1'b0}});
  assign w_pend_arm  = (r_state == S_SETTLE) || (r_state == S_START) || (r_state == S_RUN) ||
                       (r_state == S_EVAL) || (r_state == S_FORCE);

  // Primitive status crosses from the SEDCLKOUT domain through 2-flop synchronizers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sync    <= 2'b00;
      r_done_sync   <= 2'b00;
      r_inprog_sync <= 2'b00;
      r_done_d      <= 1'b0;
    end else begin
      r_err_sync    <= {r_err_sync[0], i_sederr};
      r_done_sync   <= {r_done_sync[0], i_seddone};
      r_inprog_sync <= {r_inprog_sync[0], i_sedinprog};
      r_done_d      <= r_done_sync[1];
    end
  end

  // Next-state logic; one shared counter serves interval, settle, watchdogs and force length.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_set    = 1'b0;
    w_chk_inc   = 1'b0;
    w_err_hit   = 1'b0;
    w_frc_fail  = 1'b0;
    w_frc_pass  = 1'b0;
    w_pend_clr  = 1'b0;
    if (!i_en && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
      w_state_nxt = S_ABORT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = i_interval;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_pend_frc || i_frc_req) begin
            w_state_nxt = S_FORCE;
            w_cnt_nxt   = LD_FRC;
            w_pend_clr  = 1'b1;
          end else if (r_pend_req || i_req || w_cnt_zero) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = LD_SETTLE;
            w_pend_clr  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_SETTLE: begin
          if (w_cnt_zero) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = LD_START;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_START: begin
          if (w_inprog) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = LD_RUN;
          end else if (w_cnt_zero) begin
            w_state_nxt = S_ABORT;
            w_to_set    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_RUN: begin
          if (w_done_edge) begin
            w_state_nxt = S_EVAL;
            w_chk_inc   = 1'b1;
            w_err_hit   = w_err;
          end else if (w_cnt_zero) begin
            w_state_nxt = S_ABORT;
            w_to_set    = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_EVAL: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = i_interval;
        end
        S_FORCE: begin
          if (w_cnt_zero) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = i_interval;
            w_frc_pass  = w_err;
            w_frc_fail  = ~w_err;
          end else begin
            w_cnt_nxt = r_cnt - ONE;
          end
        end
        S_ABORT: begin
          if (i_en) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = i_interval;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counter, pending request and primitive drives (decoded from the next state).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_pend_req  <= 1'b0;
      r_pend_frc  <= 1'b0;
      r_sedenable <= 1'b0;
      r_sedstart  <= 1'b0;
      r_sedfrcerr <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sedenable <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_START) ||
                     (w_state_nxt == S_RUN) || (w_state_nxt == S_FORCE);
      r_sedstart  <= (w_state_nxt == S_START);
      r_sedfrcerr <= (w_state_nxt == S_FORCE);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_WAIT);
      if (w_pend_clr || (r_state == S_ABORT)) begin
        r_pend_req <= 1'b0;
        r_pend_frc <= 1'b0;
      end else if (w_pend_arm) begin
        if (i_frc_req) r_pend_frc <= 1'b1;
        if (i_req)     r_pend_req <= 1'b1;
      end
    end
  end

  // Sticky flags and counters; a new set beats a coincident clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sticky <= 1'b0;
      r_frc_fail   <= 1'b0;
      r_timeout    <= 1'b0;
      r_irq        <= 1'b0;
      r_chk_cnt    <= 16'd0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_irq <= w_err_hit | w_frc_fail | w_to_set;
      if (w_err_hit)      r_err_sticky <= 1'b1;
      else if (i_err_clr) r_err_sticky <= 1'b0;
      if (w_frc_fail)                   r_frc_fail <= 1'b1;
      else if (i_err_clr || w_frc_pass) r_frc_fail <= 1'b0;
      if (w_to_set)       r_timeout <= 1'b1;
      else if (i_err_clr) r_timeout <= 1'b0;
      if (w_chk_inc) r_chk_cnt <= r_chk_cnt + 16'd1;
      if (w_err_hit && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_sedenable  = r_sedenable;
  assign o_sedstart   = r_sedstart;
  assign o_sedfrcerr  = r_sedfrcerr;
  assign o_busy       = r_busy;
  assign o_err_sticky = r_err_sticky;
  assign o_frc_fail   = r_frc_fail;
  assign o_timeout    = r_timeout;
  assign o_irq        = r_irq;
  assign o_chk_cnt    = r_chk_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_sed_scheduler.sv
// Self-checking bench for sed_scheduler: behavioural SEDAA primitive model plus
// directed and randomized check sequences against expectations derived from the rules.
module tb_sed_scheduler;
  localparam int CNT_W    = 32;
  localparam int START_TO = 64;
  localparam int RUN_TO   = 500;
  localparam int SETTLE   = 8;
  localparam int FRC_LEN  = 16;
  localparam int MDL_INPROG_DLY = 3;   // primitive raises INPROG this many clocks after SEDSTART
  localparam int SYNC_LAT       = 2;

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, req = 1'b0, frc_req = 1'b0, err_clr = 1'b0;
  logic seddone = 1'b0, sedinprog = 1'b0, sederr, r_frc_dly = 1'b0;
  logic [CNT_W-1:0] interval = '0;
  logic o_sedenable, o_sedstart, o_sedfrcerr, o_busy, o_err_sticky, o_frc_fail, o_timeout, o_irq;
  logic [15:0] o_chk_cnt;
  logic [7:0]  o_err_cnt;

  int n_tests = 0, n_fail = 0, irq_seen = 0;
  int m_err_mode = 0;              // 0: SEDERR low, 1: SEDERR high, 2: follows SEDFRCERR after 10 ns
  bit m_inprog_en = 1'b1, m_done_en = 1'b1;

  always #5 clk = ~clk;

  sed_scheduler #(.CNT_W(CNT_W), .START_TO(START_TO), .RUN_TO(RUN_TO), .SETTLE(SETTLE), .FRC_LEN(FRC_LEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_interval(interval), .i_req(req),
    .i_frc_req(frc_req), .i_err_clr(err_clr), .i_sederr(sederr), .i_seddone(seddone),
    .i_sedinprog(sedinprog), .o_sedenable(o_sedenable), .o_sedstart(o_sedstart),
    .o_sedfrcerr(o_sedfrcerr), .o_busy(o_busy), .o_err_sticky(o_err_sticky),
    .o_frc_fail(o_frc_fail), .o_timeout(o_timeout), .o_irq(o_irq), .o_chk_cnt(o_chk_cnt),
    .o_err_cnt(o_err_cnt));

  assign sederr = (m_err_mode == 2) ? r_frc_dly : (m_err_mode == 1);

  always @(posedge clk) if (o_irq === 1'b1) irq_seen <= irq_seen + 1;

  initial forever begin
    @(o_sedfrcerr);
    #10;
    r_frc_dly = o_sedfrcerr;
  end

  // Primitive model: INPROG a few clocks after SEDSTART, 20-clock CRC run, then a DONE pulse.
  initial begin
    int k;
    forever begin
      @(posedge o_sedstart);
      if (m_inprog_en) begin
        repeat (MDL_INPROG_DLY) @(posedge clk);
        #3 sedinprog = 1'b1;
        k = 0;
        while (k < 20 && o_sedenable === 1'b1) begin @(posedge clk); k++; end
        #3 sedinprog = 1'b0;
        if (m_done_en && o_sedenable === 1'b1) begin
          seddone = 1'b1;
          repeat (4) @(posedge clk);
          #3 seddone = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "global time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return o_sedenable;
      1: return o_sedstart;
      2: return o_sedfrcerr;
      3: return o_timeout;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (sig(sel) !== val && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic wait_chk(input int target, input int budget, output bit ok);
    int n = 0;
    while (o_chk_cnt !== 16'(target) && n < budget) begin @(negedge clk); n++; end
    ok = (o_chk_cnt === 16'(target));
  endtask

  task automatic pulse_req();
    req = 1'b1; @(negedge clk); req = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    int n, k, e, iv, base_irq, exp_chk, exp_err, n_to;
    bit ok, exp_sticky;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_sedenable, o_sedstart, o_sedfrcerr, o_busy, o_err_sticky, o_frc_fail,
                          o_timeout, o_irq, o_chk_cnt, o_err_cnt}, 64'd0);
    rst_n = 1'b1;
    req = 1'b1; frc_req = 1'b1; @(negedge clk); req = 1'b0; frc_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ignores_req", {o_busy, o_sedenable, o_sedfrcerr}, 64'd0);

    // First periodic check, INTERVAL=10, clean CRC
    interval = 10; en = 1'b1;
    wait_sig(0, 1'b1, 100, n); chk("first_wait_len", n, 10 + 2);
    base_irq = irq_seen;
    wait_sig(1, 1'b1, 40, n); chk("settle_len", n, SETTLE);
    wait_sig(1, 1'b0, 40, n); chk("start_hold", n, MDL_INPROG_DLY + SYNC_LAT + 1);
    chk("enable_in_run", o_sedenable, 1);
    wait_chk(1, 100, ok); chk("chk_cnt_first", o_chk_cnt, 1);
    wait_sig(0, 1'b1, 100, n); chk("eval_to_next_enable", n, 10 + 2);
    chk("irq_clean_check", irq_seen - base_irq, 0);

    // Second check with SEDERR held high, then ERR_CLR
    m_err_mode = 1;
    wait_chk(2, 100, ok);
    chk("err_sticky_set", o_err_sticky, 1);
    chk("err_cnt_one", o_err_cnt, 1);
    chk("err_irq_pulse", o_irq, 1);
    @(negedge clk); chk("err_irq_one_cycle", o_irq, 0);
    m_err_mode = 0;
    pulse_clr();
    chk("err_clr_sticky", o_err_sticky, 0);
    chk("err_clr_keeps_cnt", o_err_cnt, 1);
    exp_chk = 2; exp_err = 1; exp_sticky = 1'b0;
    wait_sig(0, 1'b1, 100, n);

    // Randomized checks: error outcome and interval per check
    for (int i = 0; i < 6; i++) begin
      e  = $urandom_range(0, 1);
      iv = $urandom_range(0, 12);
      m_err_mode = e; interval = iv;
      wait_chk(exp_chk + 1, 200, ok);
      exp_chk++;
      if (e == 1) begin exp_sticky = 1'b1; if (exp_err < 255) exp_err++; end
      chk("rnd_chk_cnt", o_chk_cnt, exp_chk);
      chk("rnd_err_cnt", o_err_cnt, exp_err);
      chk("rnd_sticky", o_err_sticky, exp_sticky);
      chk("rnd_irq", o_irq, e);
      wait_sig(0, 1'b1, 100, n); chk("rnd_wait_len", n, iv + 2);
    end

    // 300 back-to-back erroring checks saturate ERR_CNT
    interval = 0; m_err_mode = 1; n_to = 0;
    for (int i = 0; i < 300; i++) begin
      wait_chk(exp_chk + 1, 200, ok);
      if (!ok) n_to++;
      exp_chk++;
      if (exp_err < 255) exp_err++;
    end
    chk("err300_no_stall", n_to, 0);
    chk("err_cnt_saturated", o_err_cnt, 8'hFF);
    chk("chk_cnt_after_300", o_chk_cnt, exp_chk % 65536);

    // Forced-error self-test: pass, then fail
    interval = 1000; m_err_mode = 2;
    @(negedge clk);
    base_irq = irq_seen;
    frc_req = 1'b1; @(negedge clk); frc_req = 1'b0;
    chk("frc_rise", o_sedfrcerr, 1);
    wait_sig(2, 1'b0, 100, n); chk("frc_len_pass", n, FRC_LEN);
    chk("frc_pass_flag", o_frc_fail, 0);
    chk("frc_pass_irq", o_irq, 0);
    chk("frc_chk_cnt_unch", o_chk_cnt, exp_chk % 65536);
    m_err_mode = 0;
    frc_req = 1'b1; @(negedge clk); frc_req = 1'b0;
    wait_sig(2, 1'b0, 100, n); chk("frc_len_fail", n, FRC_LEN);
    chk("frc_fail_flag", o_frc_fail, 1);
    chk("frc_fail_irq", o_irq, 1);
    chk("frc_sticky_untouched", o_err_sticky, 1);
    chk("frc_err_cnt_untouched", o_err_cnt, 8'hFF);
    @(negedge clk);
    chk("frc_irq_count", irq_seen - base_irq, 1);
    pulse_clr();
    chk("clr_frc_fail", {o_frc_fail, o_err_sticky}, 0);

    // START watchdog: primitive never reports INPROG
    m_inprog_en = 1'b0;
    pulse_req();
    chk("req_to_enable", o_sedenable, 1);
    wait_sig(1, 1'b1, 40, n);
    wait_sig(3, 1'b1, 200, n); chk("start_timeout_at", n, START_TO);
    chk("start_to_drives_off", {o_sedenable, o_sedstart}, 0);
    chk("start_to_irq", o_irq, 1);
    pulse_clr();
    chk("start_to_cleared", o_timeout, 0);

    // RUN watchdog: primitive never pulses DONE
    m_inprog_en = 1'b1; m_done_en = 1'b0;
    pulse_req();
    wait_sig(1, 1'b1, 40, n);
    wait_sig(1, 1'b0, 40, n);
    wait_sig(3, 1'b1, 1000, n); chk("run_timeout_at", n, RUN_TO);
    chk("run_to_enable_off", o_sedenable, 0);
    chk("run_to_chk_unch", o_chk_cnt, exp_chk % 65536);
    pulse_clr();

    // EN dropped mid-RUN
    m_done_en = 1'b1;
    pulse_req();
    wait_sig(1, 1'b1, 40, n);
    wait_sig(1, 1'b0, 40, n);
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_drives_off", {o_sedenable, o_sedstart, o_sedfrcerr}, 0);
    chk("abort_busy", o_busy, 1);
    @(negedge clk); chk("idle_after_abort", o_busy, 0);
    repeat (40) @(negedge clk);
    chk("abort_chk_unch", o_chk_cnt, exp_chk % 65536);

    // Three REQs during RUN collapse into one immediate extra check
    en = 1'b1; @(negedge clk);
    pulse_req();
    wait_sig(1, 1'b1, 40, n);
    wait_sig(1, 1'b0, 40, n);
    for (int i = 0; i < 3; i++) begin pulse_req(); repeat (2) @(negedge clk); end
    wait_chk(exp_chk + 1, 200, ok); exp_chk++;
    chk("req_check_done", o_chk_cnt, exp_chk % 65536);
    wait_sig(0, 1'b1, 20, n); chk("pending_served", n, 2);
    wait_chk(exp_chk + 1, 200, ok); exp_chk++;
    chk("pending_check_done", o_chk_cnt, exp_chk % 65536);
    k = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (o_sedenable === 1'b1) k++; end
    chk("no_extra_check", k, 0);

    // Reset asserted during START
    m_inprog_en = 1'b0;
    pulse_req();
    wait_sig(1, 1'b1, 40, n);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_drives", {o_sedenable, o_sedstart, o_sedfrcerr}, 0);
    chk("rst_status", {o_busy, o_err_sticky, o_frc_fail, o_timeout, o_irq, o_chk_cnt, o_err_cnt}, 0);
    interval = 0; m_inprog_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    wait_sig(0, 1'b1, 20, n); chk("restart_from_idle", n, 2);
    wait_chk(1, 200, ok); chk("restart_check_done", o_chk_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sed_scheduler.md
# sed_scheduler

Sequencing controller for the SEDAA soft-error-detection primitive. It drives SEDENABLE/SEDSTART/SEDFRCERR and monitors SEDDONE/SEDERR/SEDINPROG. It runs periodic or on-demand configuration-memory CRC checks and guards each check with a watchdog. Results are exposed as a sticky error flag, counters and a one-cycle interrupt for the fabric-side supervisor.

## Interface
- CNT_W, 32: width of interval and watchdog counters
- START_TO, 64: CLK cycles allowed from SEDSTART assertion to synchronized SEDINPROG high
- RUN_TO, 32'd100000000: CLK cycles allowed from SEDINPROG high to SEDDONE pulse
- SETTLE, 8: CLK cycles SEDENABLE is held before SEDSTART is raised
- FRC_LEN, 16: CLK cycles SEDFRCERR is held during a forced-error self-test

- CLK  in  1  controller clock, independent of SEDCLKOUT
- RSTN  in  1  asynchronous active-low reset
- EN  in  1  scheduler enable; low aborts any check in progress
- INTERVAL  in  CNT_W  CLK cycles between the end of one check and the start of the next; 0 = back-to-back
- REQ  in  1  pulse; request one immediate check
- FRC_REQ  in  1  pulse; request a forced-error self-test
- ERR_CLR  in  1  pulse; clear ERR_STICKY and FRC_FAIL
- SEDERR, SEDDONE, SEDINPROG  in  1  from the primitive, asynchronous to CLK
- SEDENABLE, SEDSTART, SEDFRCERR  out  1  to the primitive, registered
- BUSY  out  1  high in every state except IDLE and WAIT
- ERR_STICKY  out  1  CRC error seen since the last clear
- FRC_FAIL  out  1  last self-test did not see SEDERR
- TIMEOUT  out  1  sticky; watchdog fired; cleared by ERR_CLR
- IRQ  out  1  one-cycle pulse on any error, self-test fail or timeout
- CHK_CNT  out  16  completed checks; wraps
- ERR_CNT  out  8  CRC errors; saturates at 8'hFF

## Operation
- All three primitive inputs pass through 2-flop synchronizers on CLK. The done event is the rising edge of synchronized SEDDONE.
- CLK must be at least 3× the SEDCLKOUT frequency.
- States: IDLE, WAIT, SETTLE, START, RUN, EVAL, FORCE, ABORT.
- IDLE:
  - EN=1 → WAIT, with the interval counter loaded from INTERVAL.
  - REQ or FRC_REQ while EN=0 is ignored.
- WAIT:
  - Counter decrements each cycle. At 0, or on REQ → SETTLE.
  - FRC_REQ takes priority over REQ and expiry → FORCE.
- SETTLE: SEDENABLE=1. After SETTLE cycles → START.
- START: SEDSTART=1, held until synchronized SEDINPROG=1 → RUN, then SEDSTART drops. If START_TO expires first: TIMEOUT=1, IRQ → ABORT.
- RUN:
  - SEDSTART=0, SEDENABLE=1, watchdog counting.
  - Done edge → EVAL.
  - RUN_TO expiry: TIMEOUT=1, IRQ → ABORT.
- EVAL (1 cycle):
  - CHK_CNT+1.
  - If synchronized SEDERR=1: ERR_STICKY=1, ERR_CNT+1 (saturating), IRQ.
  - Then → WAIT with INTERVAL reloaded.
- FORCE:
  - SEDENABLE=1, SEDFRCERR=1 for FRC_LEN cycles. Synchronized SEDERR is sampled on the last cycle.
  - If SEDERR was not sampled high: FRC_FAIL=1, IRQ.
  - SEDFRCERR drops, then → WAIT. ERR_STICKY and ERR_CNT are not touched.
- ABORT (1 cycle): all primitive outputs 0 → IDLE (EN=0) or WAIT (EN=1).
- EN falling in any state → ABORT next cycle. No EVAL, no count update.
- REQ/FRC_REQ arriving in SETTLE/START/RUN/EVAL/FORCE set a single pending bit (FRC has priority). The pending bit is served on the next WAIT entry, bypassing the interval. Multiple pending requests collapse to one.
- ERR_CLR coincident with a new error: the set wins.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; pending bits 0.
- Output registers are updated on the CLK edge of the state transition. SEDSTART rises SETTLE cycles after SEDENABLE.
- REQ in WAIT → SEDENABLE high on the next cycle.
- Done edge → EVAL in 3 CLK cycles (2 synchronizer + 1 edge detect). IRQ/counters update in the EVAL cycle. The WAIT countdown begins in the following cycle.
- INTERVAL=0: WAIT lasts exactly 1 cycle.
- INTERVAL is sampled only on WAIT entry.
- Asserting RSTN low mid-check drops all primitive drives to 0 immediately (asynchronous).

## Test plan
- EN=1, INTERVAL=10, primitive model with 35K density scaled to sed_count=20, SEDERR=0:
  - Required: SEDSTART rises 8 cycles after SEDENABLE and drops after INPROG.
  - CHK_CNT=1 after first done; second check starts 11 cycles after EVAL.
  - IRQ stays 0.
- Hold SEDERR=1 through a check: ERR_STICKY=1, ERR_CNT=1, IRQ one cycle. ERR_CLR → ERR_STICKY=0, ERR_CNT still 1. Drive 300 errors → ERR_CNT=8'hFF.
- FRC_REQ in WAIT with the model's SEDERR following SEDFRCERR after 10 ns: SEDFRCERR high for 16 cycles, FRC_FAIL=0. Repeat with SEDERR tied 0 → FRC_FAIL=1, IRQ pulse.
- Model never asserts SEDINPROG, START_TO=64: TIMEOUT=1 and IRQ at cycle 64 of START, SEDENABLE=0 the next cycle. Same with SEDDONE suppressed and RUN_TO=500 → TIMEOUT in RUN.
- EN dropped mid-RUN: ABORT, all primitive outputs 0, CHK_CNT unchanged. Three REQ pulses during RUN → exactly one extra check, immediately after EVAL.
- RSTN asserted in START: SEDSTART/SEDENABLE are 0 before the next CLK edge, all status outputs are 0, and the FSM restarts from IDLE after release.
